// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Narrower data words are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    logic p;
    case (mode)
      PAR_ODD:  p = ~^data;
      PAR_EVEN: p = ^data;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter framing a parallel byte onto txd, one bit per external baud tick.
// Start, LSB-first data, optional parity and stop bits; the clock is never divided here.
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bps_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 busy,
  output logic                 txd
);

  localparam int               CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [1:0]       PAR_MODE  = 2'(PARITY);

  state_t                 state;
  logic [DATA_BITS-1:0]   shift;
  logic                   par;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   stop_cnt;

  assign tx_ready = (state == ST_IDLE);

  // txd is loaded together with each state change so the pin always matches the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      shift    <= '0;
      par      <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (tx_valid) begin
            shift <= tx_data;
            par   <= parity_bit(8'(tx_data), PAR_MODE);
            busy  <= 1'b1;
            state <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (bps_tick) begin
            txd   <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (bps_tick) begin
            txd     <= shift[0];
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bps_tick) begin
            shift <= shift >> 1;
            if (bit_cnt == LAST_BIT) begin
              if (PAR_MODE != PAR_NONE) begin
                txd   <= par;
                state <= ST_PARITY;
              end else begin
                txd      <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= ST_STOP;
              end
            end else begin
              txd     <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bps_tick) begin
            txd      <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bps_tick) begin
            if (stop_cnt == LAST_STOP) begin
              tx_done <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed bench for uart_tx_tick: four parameter variants share clock, reset, tick and data.
module tb_uart_tx_tick;

  logic       clk = 1'b0;
  logic       rst;
  logic       bps_tick;
  logic [7:0] tx_data;
  logic [3:0] valid_v;
  logic [3:0] ready_v, done_v, busy_v, txd_v;
  int         tcnt = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // instance index: 0 = no parity, 1 = even parity, 2 = odd parity, 3 = two stop bits
  localparam int U_NP = 0, U_EV = 1, U_OD = 2, U_S2 = 3;

  always #5 clk = ~clk;

  // divide-by-4 baud tick generator
  always @(posedge clk) tcnt <= (tcnt + 1) % 4;
  assign bps_tick = (tcnt == 3);

  uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_np (
    .clk(clk), .rst(rst), .bps_tick(bps_tick), .tx_data(tx_data), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx_done(done_v[0]), .busy(busy_v[0]), .txd(txd_v[0]));
  uart_tx_tick #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_ev (
    .clk(clk), .rst(rst), .bps_tick(bps_tick), .tx_data(tx_data), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx_done(done_v[1]), .busy(busy_v[1]), .txd(txd_v[1]));
  uart_tx_tick #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_od (
    .clk(clk), .rst(rst), .bps_tick(bps_tick), .tx_data(tx_data), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx_done(done_v[2]), .busy(busy_v[2]), .txd(txd_v[2]));
  uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_s2 (
    .clk(clk), .rst(rst), .bps_tick(bps_tick), .tx_data(tx_data), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .tx_done(done_v[3]), .busy(busy_v[3]), .txd(txd_v[3]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // advance through the next clock edge at which bps_tick is sampled high
  task automatic wait_tick();
    int c = 0;
    while (!bps_tick && c < 8) begin
      step();
      c++;
    end
    if (!bps_tick) chk("tick_timeout", 16'd0, 16'd1);
    step();
  endtask

  task automatic send(input int idx, input logic [7:0] d, input bit on_tick, input bit hold);
    int c = 0;
    while (!(ready_v[idx] && (bps_tick == on_tick)) && c < 64) begin
      step();
      c++;
    end
    if (!ready_v[idx]) chk("ready_timeout", 16'd0, 16'd1);
    tx_data      = d;
    valid_v[idx] = 1'b1;
    step();
    if (!hold) valid_v[idx] = 1'b0;
  endtask

  // seq holds the n line levels in transmission order, first bit in seq[n-1]
  task automatic check_frame(input string tag, input int idx, input int n, input logic [15:0] seq);
    for (int k = 0; k < n; k++) begin
      wait_tick();
      chk($sformatf("%s_bit%0d", tag, k), 16'(txd_v[idx]), 16'(seq[n-1-k]));
      chk($sformatf("%s_busy%0d", tag, k), 16'(busy_v[idx]), 16'd1);
      if (k == 0) chk({tag, "_ready_low"}, 16'(ready_v[idx]), 16'd0);
      if (k == n-1) chk({tag, "_no_early_done"}, 16'(done_v[idx]), 16'd0);
    end
    wait_tick();
    chk({tag, "_done"}, 16'(done_v[idx]), 16'd1);
    chk({tag, "_idle_busy"}, 16'(busy_v[idx]), 16'd0);
    chk({tag, "_idle_ready"}, 16'(ready_v[idx]), 16'd1);
    chk({tag, "_idle_txd"}, 16'(txd_v[idx]), 16'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    logic seen_low;
    rst     = 1'b1;
    valid_v = 4'b0000;
    tx_data = 8'h00;
    repeat (3) step();
    chk("rst_txd",   16'(txd_v),   16'hF);
    chk("rst_ready", 16'(ready_v), 16'hF);
    chk("rst_busy",  16'(busy_v),  16'h0);
    chk("rst_done",  16'(done_v),  16'h0);
    rst = 1'b0;
    repeat (2) step();

    // 0x55, no parity: 0,1,0,1,0,1,0,1,0,1
    send(U_NP, 8'h55, 1'b0, 1'b0);
    chk("t1_align_txd", 16'(txd_v[U_NP]), 16'd1);
    check_frame("t1", U_NP, 10, 16'(10'b0_10101010_1));
    step();
    chk("t1_done_pulse", 16'(done_v[U_NP]), 16'd0);

    // 0xA3: data 1,1,0,0,0,1,0,1; even parity 0, odd parity 1
    send(U_EV, 8'hA3, 1'b0, 1'b0);
    check_frame("t2e", U_EV, 11, 16'(11'b0_11000101_0_1));
    send(U_OD, 8'hA3, 1'b0, 1'b0);
    check_frame("t2o", U_OD, 11, 16'(11'b0_11000101_1_1));

    // 0x00 with two stop bits: nine lows then two highs
    send(U_S2, 8'h00, 1'b0, 1'b0);
    check_frame("t3", U_S2, 11, 16'(11'b0_00000000_11));

    // handshake coinciding with a tick: that tick is not counted
    send(U_NP, 8'hA3, 1'b1, 1'b0);
    chk("t4_hs_txd", 16'(txd_v[U_NP]), 16'd1);
    repeat (3) step();
    chk("t4_align_hold", 16'(txd_v[U_NP]), 16'd1);
    step();
    chk("t4_start", 16'(txd_v[U_NP]), 16'd0);
    check_frame("t4", U_NP, 9, 16'(9'b11000101_1));

    // back-to-back with tx_valid held; data changed after the latch must not matter
    send(U_NP, 8'h12, 1'b0, 1'b1);
    tx_data = 8'h34;
    check_frame("t5a", U_NP, 10, 16'(10'b0_01001000_1));
    step();
    valid_v[U_NP] = 1'b0;
    chk("t5_b2b_ready", 16'(ready_v[U_NP]), 16'd0);
    chk("t5_b2b_busy",  16'(busy_v[U_NP]),  16'd1);
    tx_data = 8'hFF;
    check_frame("t5b", U_NP, 10, 16'(10'b0_00101100_1));

    // asynchronous reset during data bit 3 of 0xFF
    send(U_NP, 8'hFF, 1'b0, 1'b0);
    repeat (5) wait_tick();
    chk("t6_bit3", 16'(txd_v[U_NP]), 16'd1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_txd",   16'(txd_v[U_NP]),   16'd1);
    chk("t6_async_busy",  16'(busy_v[U_NP]),  16'd0);
    chk("t6_async_ready", 16'(ready_v[U_NP]), 16'd1);
    step();
    rst = 1'b0;
    seen_done = 1'b0;
    seen_low  = 1'b0;
    repeat (40) begin
      step();
      seen_done = seen_done | done_v[U_NP];
      seen_low  = seen_low | ~txd_v[U_NP];
    end
    chk("t6_no_done",   16'(seen_done), 16'd0);
    chk("t6_line_idle", 16'(seen_low),  16'd0);
    send(U_NP, 8'h0F, 1'b0, 1'b0);
    check_frame("t6", U_NP, 10, 16'(10'b0_11110000_1));

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
